// File: rtl/buffer_pkg.sv
// Shared constants, flit type and sizing helper for the virtual-channel buffers.
package buffer_pkg;

   localparam int FLIT_WIDTH    = 64;
   localparam int NUM_VC_DEF    = 2;
   localparam int BUF_DEPTH_DEF = 4;

   typedef logic [FLIT_WIDTH-1:0] flit_t;

   // Index width that never collapses to zero bits, even for a single VC.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/buffer_fifo_core.sv
// One single-VC synchronous FIFO: register storage, wrapping pointers, explicit count, flags.
// Requests arrive pre-decoded for this VC; qualification against full/empty happens here.
module buffer_fifo_core #(
   parameter int WIDTH        = 64,
   parameter int DEPTH        = 4,
   parameter int AFULL_THRESH = DEPTH - 1,
   parameter int CW           = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic [CW-1:0]    count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    wptr_reg;
   logic [PW-1:0]    rptr_reg;
   logic [CW-1:0]    count_reg;
   logic             wq;
   logic             rq;

   assign wq = wr_en & ~full;
   assign rq = rd_en & ~empty;

   // Storage is reset so the head of an idle FIFO reads as zero.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            mem_reg[gi] <= '0;
         end else if (wq && (wptr_reg == PW'(gi))) begin
            mem_reg[gi] <= data_in;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (wq) wptr_reg <= wptr_reg + 1'b1;
         if (rq) rptr_reg <= rptr_reg + 1'b1;
         case ({wq, rq})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head        = mem_reg[rptr_reg];
   assign count       = count_reg;
   assign full        = (count_reg == CW'(DEPTH));
   assign empty       = (count_reg == '0);
   assign almost_full = (count_reg >= CW'(AFULL_THRESH));

endmodule

// File: rtl/buffer_vc_fifo.sv
// NUM_VC independent FIFOs behind one shared write port and one shared read port.
// Optional sticky overflow/underflow flags are built when BUFFER_ERR_EN is defined.
module buffer_vc_fifo
   import buffer_pkg::*;
#(
   parameter  int WIDTH        = FLIT_WIDTH,
   parameter  int DEPTH        = BUF_DEPTH_DEF,
   parameter  int NUM_VC       = NUM_VC_DEF,
   parameter  int AFULL_THRESH = DEPTH - 1,
   localparam int VCW          = clog2_min1(NUM_VC),
   localparam int CW           = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [VCW-1:0]       wr_vc,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 re,
   input  logic [VCW-1:0]       rd_vc,
   output logic [WIDTH-1:0]     data_out,
   output logic [NUM_VC-1:0]    full,
   output logic [NUM_VC-1:0]    empty,
   output logic [NUM_VC-1:0]    almost_full,
   output logic [NUM_VC*CW-1:0] count
`ifdef BUFFER_ERR_EN
   ,
   output logic [NUM_VC-1:0]    err_ovf,
   output logic [NUM_VC-1:0]    err_udf
`endif
);

   logic [NUM_VC-1:0] wr_sel;
   logic [NUM_VC-1:0] rd_sel;
   logic [WIDTH-1:0]  head [NUM_VC];

   // A VC index beyond NUM_VC matches no lane, so the request is ignored.
   for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
      assign wr_sel[gi] = we & (wr_vc == VCW'(gi));
      assign rd_sel[gi] = re & (rd_vc == VCW'(gi));

      buffer_fifo_core #(
         .WIDTH        (WIDTH),
         .DEPTH        (DEPTH),
         .AFULL_THRESH (AFULL_THRESH),
         .CW           (CW)
      ) u_core (
         .clk         (clk),
         .reset       (reset),
         .wr_en       (wr_sel[gi]),
         .rd_en       (rd_sel[gi]),
         .data_in     (data_in),
         .head        (head[gi]),
         .full        (full[gi]),
         .empty       (empty[gi]),
         .almost_full (almost_full[gi]),
         .count       (count[gi*CW +: CW])
      );
   end

   always_comb begin
      data_out = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (rd_vc == VCW'(v)) data_out = head[v];
      end
   end

`ifdef BUFFER_ERR_EN
   logic [NUM_VC-1:0] err_ovf_reg;
   logic [NUM_VC-1:0] err_udf_reg;

   // Flags use the pre-edge full/empty, i.e. the same view that rejected the request.
   for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_err
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            err_ovf_reg[gi] <= 1'b0;
            err_udf_reg[gi] <= 1'b0;
         end else begin
            if (wr_sel[gi] && full[gi])  err_ovf_reg[gi] <= 1'b1;
            if (rd_sel[gi] && empty[gi]) err_udf_reg[gi] <= 1'b1;
         end
      end
   end

   assign err_ovf = err_ovf_reg;
   assign err_udf = err_udf_reg;
`endif

endmodule

// File: tb/tb_buffer_vc_fifo.sv
// Directed and randomized checks of buffer_vc_fifo against per-VC queue reference model.
module tb_buffer_vc_fifo;
   import buffer_pkg::*;

   localparam int DEPTH  = 4;
   localparam int NUM_VC = 2;
   localparam int CW     = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [0:0]  wr_vc = '0;
   logic [0:0]  rd_vc = '0;
   flit_t       data_in = '0;
   flit_t       data_out;
   logic [NUM_VC-1:0]    full;
   logic [NUM_VC-1:0]    empty;
   logic [NUM_VC-1:0]    almost_full;
   logic [NUM_VC*CW-1:0] count;
`ifdef BUFFER_ERR_EN
   logic [NUM_VC-1:0]    err_ovf;
   logic [NUM_VC-1:0]    err_udf;
`endif

   int tests = 0;
   int failed = 0;

   flit_t q0[$];
   flit_t q1[$];
   bit    movf [NUM_VC];
   bit    mudf [NUM_VC];

   buffer_vc_fifo #(
      .WIDTH  (FLIT_WIDTH),
      .DEPTH  (DEPTH),
      .NUM_VC (NUM_VC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .we          (we),
      .wr_vc       (wr_vc),
      .data_in     (data_in),
      .re          (re),
      .rd_vc       (rd_vc),
      .data_out    (data_out),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .count       (count)
`ifdef BUFFER_ERR_EN
      ,
      .err_ovf     (err_ovf),
      .err_udf     (err_udf)
`endif
   );

   always #5 clk = ~clk;

   function automatic int msize(input int v);
      return (v == 0) ? q0.size() : q1.size();
   endfunction

   function automatic flit_t mfront(input int v);
      return (v == 0) ? q0[0] : q1[0];
   endfunction

   task automatic mpush(input int v, input flit_t d);
      if (v == 0) q0.push_back(d);
      else        q1.push_back(d);
   endtask

   task automatic mpop(input int v);
      flit_t tmp;
      if (v == 0) tmp = q0.pop_front();
      else        tmp = q1.pop_front();
   endtask

   task automatic mclear();
      q0.delete();
      q1.delete();
      for (int v = 0; v < NUM_VC; v++) begin
         movf[v] = 1'b0;
         mudf[v] = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int v = 0; v < NUM_VC; v++) begin
         chk({tag, "_count"}, 64'(count[v*CW +: CW]), 64'(msize(v)));
         chk({tag, "_full"},  64'(full[v]),  64'(msize(v) == DEPTH));
         chk({tag, "_empty"}, 64'(empty[v]), 64'(msize(v) == 0));
         chk({tag, "_afull"}, 64'(almost_full[v]), 64'(msize(v) >= DEPTH - 1));
`ifdef BUFFER_ERR_EN
         chk({tag, "_ovf"}, 64'(err_ovf[v]), 64'(movf[v]));
         chk({tag, "_udf"}, 64'(err_udf[v]), 64'(mudf[v]));
`endif
      end
      if (msize(int'(rd_vc)) > 0) chk({tag, "_dout"}, data_out, mfront(int'(rd_vc)));
   endtask

   // One clock: drive request, predict with the pre-edge model, then compare.
   task automatic step(input string tag, input bit w, input int wv, input flit_t d,
                       input bit r, input int rv);
      bit do_w;
      bit do_r;
      we      = w;
      wr_vc   = wv[0];
      data_in = d;
      re      = r;
      rd_vc   = rv[0];
      do_w = w && (msize(wv) < DEPTH);
      do_r = r && (msize(rv) > 0);
      if (w && msize(wv) == DEPTH) movf[wv] = 1'b1;
      if (r && msize(rv) == 0)     mudf[rv] = 1'b1;
      @(posedge clk);
      #1;
      if (do_r) mpop(rv);
      if (do_w) mpush(wv, d);
      we = 1'b0;
      re = 1'b0;
      check_all(tag);
   endtask

   initial begin
      mclear();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_full",  64'(full),  64'(2'b00));
      chk("rst_empty", 64'(empty), 64'(2'b11));
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_dout",  data_out,   64'd0);
      check_all("rst");

      // Mid-stream reset with three flits in VC0.
      for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, flit_t'(64'h30 + i), 0, 0);
      chk("pre_rst_cnt3", 64'(count[0 +: CW]), 64'd3);
      reset = 1'b1;
      #1;
      mclear();
      chk("mid_rst_count", 64'(count[0 +: CW]), 64'd0);
      chk("mid_rst_empty", 64'(empty[0]), 64'd1);
      check_all("mid_rst");
      @(posedge clk);
      #3;
      reset = 1'b0;

      // Fill VC0, overflow attempt, drain in order.
      rd_vc = 1'b0;
      for (int i = 0; i < 4; i++) step("fill", 1, 0, flit_t'(64'hA0 + i), 0, 0);
      chk("fill_full", 64'(full[0]), 64'd1);
      step("ovf", 1, 0, flit_t'(64'hFF), 0, 0);
      chk("ovf_count", 64'(count[0 +: CW]), 64'd4);
      chk("drain_head", data_out, 64'hA0);
      for (int i = 0; i < 4; i++) step("drain", 0, 0, '0, 1, 0);
      chk("drain_empty", 64'(empty[0]), 64'd1);

      // Wrap-around on VC1.
      for (int k = 0; k < 10; k++) begin
         step("wrap_w", 1, 1, flit_t'({32'hB000, k[15:0], 16'h0}), 0, 1);
         step("wrap_w", 1, 1, flit_t'({32'hB000, k[15:0], 16'h1}), 0, 1);
         step("wrap_r", 0, 1, '0, 1, 1);
         step("wrap_r", 0, 1, '0, 1, 1);
      end
      chk("wrap_count", 64'(count[CW +: CW]), 64'd0);

      // Simultaneous read/write on VC0.
      step("sim2_fill", 1, 0, flit_t'(64'hC0), 0, 0);
      step("sim2_fill", 1, 0, flit_t'(64'hC1), 0, 0);
      step("sim2", 1, 0, flit_t'(64'hC2), 1, 0);
      chk("sim2_count", 64'(count[0 +: CW]), 64'd2);
      step("simf_fill", 1, 0, flit_t'(64'hC3), 0, 0);
      step("simf_fill", 1, 0, flit_t'(64'hC4), 0, 0);
      step("simf", 1, 0, flit_t'(64'hEE), 1, 0);
      chk("simf_count", 64'(count[0 +: CW]), 64'd3);
      for (int i = 0; i < 3; i++) step("simf_drain", 0, 0, '0, 1, 0);
      step("sime", 1, 0, flit_t'(64'h55), 1, 0);
      chk("sime_count", 64'(count[0 +: CW]), 64'd1);
      chk("sime_dout", data_out, 64'h55);
      step("sime_drain", 0, 0, '0, 1, 0);

      // Cross-VC isolation: write VC0 while reading an empty VC1.
      step("xvc", 1, 0, flit_t'(64'h11), 1, 1);
      chk("xvc_cnt0", 64'(count[0 +: CW]), 64'd1);
      chk("xvc_cnt1", 64'(count[CW +: CW]), 64'd0);
      step("xvc_drain", 0, 0, '0, 1, 0);

      // almost_full rises on the third write and falls on the next read.
      step("af1", 1, 0, flit_t'(64'hD1), 0, 0);
      step("af2", 1, 0, flit_t'(64'hD2), 0, 0);
      chk("af2_low", 64'(almost_full[0]), 64'd0);
      step("af3", 1, 0, flit_t'(64'hD3), 0, 0);
      chk("af3_high", 64'(almost_full[0]), 64'd1);
      step("af_rd", 0, 0, '0, 1, 0);
      chk("af_rd_low", 64'(almost_full[0]), 64'd0);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         step("rand", ($urandom_range(0, 99) < 55), int'($urandom_range(0, 1)),
              flit_t'({$urandom, $urandom}),
              ($urandom_range(0, 99) < 50), int'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
